// File: rtl/load_store_unit_if.sv
// Data-bus handshake bundle between the load/store unit (master) and the memory slave.
interface load_store_unit_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one valid/ready bus transaction per load/store,
// stalls the datapath while it is outstanding and returns the extended load word.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        unsignedload,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned,
  output logic [1:0]  errflags,
  load_store_unit_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_valid;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [3:0]       r_bus_be;
  logic [31:0]      r_bus_wdata;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [1:0]       r_off;
  logic [31:0]      r_readdata;
  logic [1:0]       r_errflags;

  logic        w_req;
  logic        w_mis;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request decode; size 11 behaves as a word access.
  assign w_req      = memread | memwrite;
  assign w_mis      = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
  assign misaligned = (r_state == S_IDLE) & w_req & w_mis;
  assign w_start    = (r_state == S_IDLE) & w_req & ~w_mis;
  assign stall      = w_start | (r_state == S_REQ);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = writedata;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{writedata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{writedata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction uses the format latched at request time, not the live inputs.
  always_comb begin
    w_byte = bus.bus_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = bus.bus_rdata[15:8];
      2'd2:    w_byte = bus.bus_rdata[23:16];
      2'd3:    w_byte = bus.bus_rdata[31:24];
      default: w_byte = bus.bus_rdata[7:0];
    endcase
    w_half = r_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    w_load = bus.bus_rdata;
    case (r_size)
      2'b00:   w_load = {{24{w_byte[7] & ~r_uns}}, w_byte};
      2'b01:   w_load = {{16{w_half[15] & ~r_uns}}, w_half};
      default: w_load = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_off       <= '0;
      r_readdata  <= '0;
      r_errflags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (misaligned) r_errflags[0] <= 1'b1;
          if (w_start) begin
            r_bus_valid <= 1'b1;
            r_bus_we    <= memwrite;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_size      <= size;
            r_uns       <= unsignedload;
            r_off       <= addr[1:0];
            r_cnt       <= '0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          // A ready on the final allowed cycle still completes the access.
          if (bus.bus_ready) begin
            r_bus_valid <= 1'b0;
            r_readdata  <= r_bus_we ? 32'd0 : w_load;
            r_state     <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_bus_valid   <= 1'b0;
            r_errflags[1] <= 1'b1;
            r_readdata    <= 32'd0;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_readdata <= 32'd0;
          r_cnt      <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign readdata      = r_readdata;
  assign errflags      = r_errflags;
  assign bus.bus_valid = r_bus_valid;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model of each memory instruction
// compared against the DUT every cycle, plus directed and randomized instructions.
module tb_load_store_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, unsignedload;
  logic [1:0]  size;
  logic [31:0] addr, writedata;
  logic [31:0] readdata;
  logic        stall, misaligned;
  logic [1:0]  errflags;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .memread      (memread),
    .memwrite     (memwrite),
    .size         (size),
    .unsignedload (unsignedload),
    .addr         (addr),
    .writedata    (writedata),
    .readdata     (readdata),
    .stall        (stall),
    .misaligned   (misaligned),
    .errflags     (errflags),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [1:0] m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 4'(1 << off);
    if (sz == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return 32'(wd[7:0]) * 32'h0101_0101;
    if (sz == 2'b01) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input logic uns,
                                         input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    sh = 8 * off;
    v  = rd >> sh;
    if (sz == 2'b00) begin
      v = v & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'b01) begin
      v = v & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  // Presents one instruction (entered and left just after a rising edge) and
  // checks every cycle it occupies: IDLE, then REQ cycles, then DONE.
  task automatic run_instr(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int lat,
                           output int n_stall, output int n_valid);
    logic        req, mis, go, timed;
    int          nreq, total, k;
    logic [31:0] e_rd;
    logic        e_stall, e_valid;
    memread = rd; memwrite = wr; size = sz; unsignedload = uns; addr = a; writedata = wd;
    req   = rd | wr;
    mis   = req && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
    go    = req && !mis;
    timed = go && (lat >= int'(TMO));
    nreq  = (lat < int'(TMO)) ? lat + 1 : int'(TMO);
    total = go ? nreq + 2 : 1;
    e_rd  = (wr || timed) ? 32'd0 : f_load(sz, uns, a[1:0], rdat);
    n_stall = 0;
    n_valid = 0;
    for (int c = 0; c < total; c++) begin
      k = c - 1;
      if (go && c >= 1 && c <= nreq) begin
        bus_if.bus_ready = (k == lat);
        bus_if.bus_rdata = (k == lat) ? rdat : $urandom;
      end else begin
        bus_if.bus_ready = 1'($urandom);
        bus_if.bus_rdata = $urandom;
      end
      @(negedge clk);
      if (c == 0) begin
        e_stall = go; e_valid = 1'b0;
      end else if (c <= nreq) begin
        e_stall = 1'b1; e_valid = 1'b1;
      end else begin
        e_stall = 1'b0; e_valid = 1'b0;
        if (timed) m_err[1] = 1'b1;
      end
      chk("stall", 32'(stall), 32'(e_stall));
      chk("misaligned", 32'(misaligned), 32'((c == 0) && mis));
      chk("bus_valid", 32'(bus_if.bus_valid), 32'(e_valid));
      chk("readdata", readdata, (go && c == nreq + 1) ? e_rd : 32'd0);
      chk("errflags", 32'(errflags), 32'(m_err));
      if (e_valid) begin
        chk("bus_we", 32'(bus_if.bus_we), 32'(wr));
        chk("bus_addr", bus_if.bus_addr, {a[31:2], 2'b00});
        chk("bus_be", 32'(bus_if.bus_be), 32'(f_be(sz, a[1:0])));
        if (wr) chk("bus_wdata", bus_if.bus_wdata, f_wd(sz, wd));
      end
      if (stall) n_stall++;
      if (bus_if.bus_valid) n_valid++;
      if (c == 0 && mis) m_err[0] = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_errflags(input string name, input logic [1:0] exp);
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    chk(name, 32'(errflags), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ns, nv, lat;
    logic rd, wr, uns;
    logic [1:0] sz;
    logic [31:0] a;
    reset = 1'b0; memread = 1'b0; memwrite = 1'b0; size = 2'b00; unsignedload = 1'b0;
    addr = '0; writedata = '0; bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
    m_err = 2'b00;

    @(negedge clk);
    chk("rst_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("rst_we", 32'(bus_if.bus_we), 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'd0);
    chk("rst_be", 32'(bus_if.bus_be), 32'd0);
    chk("rst_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_errflags", 32'(errflags), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Hand-computed values that pin the reference functions.
    chk("pin_be_lb3", 32'(f_be(2'b00, 2'd3)), 32'h8);
    chk("pin_be_sh2", 32'(f_be(2'b01, 2'd2)), 32'hC);
    chk("pin_wd_sh", f_wd(2'b01, 32'h0000_ABCD), 32'hABCD_ABCD);
    chk("pin_lb", f_load(2'b00, 1'b0, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
    chk("pin_lbu", f_load(2'b00, 1'b1, 2'd3, 32'h80FF_1234), 32'h0000_0080);

    run_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 2, ns, nv);
    chk("lw_stall_cycles", 32'(ns), 32'd4);
    chk("lw_valid_cycles", 32'(nv), 32'd3);
    run_instr(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0003, 32'h0, 32'h80FF_1234, 1, ns, nv);
    run_instr(1'b1, 1'b0, 2'b00, 1'b1, 32'h1001_0003, 32'h0, 32'h80FF_1234, 0, ns, nv);
    run_instr(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_ABCD, $urandom, 0, ns, nv);

    run_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0006, 32'h0, 32'h0, 0, ns, nv);
    chk("mis_valid_cycles", 32'(nv), 32'd0);
    chk("mis_stall_cycles", 32'(ns), 32'd0);
    idle_errflags("err_after_mis", 2'b01);

    // Asynchronous reset in the middle of an outstanding load.
    memread = 1'b1; memwrite = 1'b0; size = 2'b10; unsignedload = 1'b0; addr = 32'h1001_0008;
    bus_if.bus_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("valid_before_rst", 32'(bus_if.bus_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("valid_async_drop", 32'(bus_if.bus_valid), 32'd0);
    chk("err_async_clear", 32'(errflags), 32'd0);
    chk("addr_async_clear", bus_if.bus_addr, 32'd0);
    chk("be_async_clear", 32'(bus_if.bus_be), 32'd0);
    m_err = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, 32'h1357_9BDF, 1, ns, nv);

    run_instr(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, 32'h0, 10, ns, nv);
    chk("to_valid_cycles", 32'(nv), 32'(TMO));
    idle_errflags("err_after_timeout", 2'b10);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rd = 1'b0; wr = 1'b0;
      end else begin
        rd = 1'($urandom); wr = 1'($urandom);
        if (!rd && !wr) rd = 1'b1;
      end
      sz  = 2'($urandom);
      uns = 1'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz[1]) a[1:0] = 2'b00;
      end
      lat = $urandom_range(0, 5);
      run_instr(rd, wr, sz, uns, a, $urandom, $urandom, lat, ns, nv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage placed directly downstream of the single-cycle datapath: it consumes the ALU result as the effective address, plus the store data and the load/store controls. It performs the access on a variable-latency data bus through a valid/ready handshake and returns the size-adjusted load word to the datapath's write-back mux. While an access is outstanding it stalls the datapath, and it flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT, default 255: maximum cycles in REQ without `bus_ready` before the access is aborted (range 1..255).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- memread  in  1  current instruction is a load.
- memwrite  in  1  current instruction is a store; takes priority if both are high.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- unsignedload  in  1  zero-extend byte/half loads (lbu/lhu); otherwise sign-extend.
- addr  in  32  effective address (datapath `aluout`).
- writedata  in  32  store data (datapath `writedata`).
- readdata  out  32  extended load result for write-back.
- stall  out  1  hold PC and register write this cycle.
- misaligned  out  1  combinational; current request is misaligned (valid in IDLE only).
- errflags  out  2  sticky status: [0] misaligned seen, [1] bus timeout seen.
- bus_valid  out  1  request valid (registered).
- bus_we  out  1  1 = write (registered).
- bus_addr  out  32  word address, {addr[31:2], 2'b00} (registered).
- bus_be  out  4  byte enables, little-endian lanes (registered).
- bus_wdata  out  32  lane-replicated store data (registered).
- bus_ready  in  1  slave accepts/completes the request this cycle.
- bus_rdata  in  32  read data, valid when `bus_ready` is high on a read.

## Operation
- States: IDLE, REQ, DONE.
- IDLE, request = memread|memwrite:
  - Aligned request: `stall` = 1 combinationally. Latch bus fields and the load format (size, unsignedload, addr[1:0]); go to REQ.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]≠0): no bus request, `stall` = 0, `misaligned` = 1, errflags[0] set, `readdata` = 0, store suppressed. Stay in IDLE.
  - No request: `stall` = 0, `readdata` = 0.
- REQ:
  - `bus_valid` = 1 and `stall` = 1. All bus fields are held constant until `bus_ready` is sampled high.
  - `bus_ready` high at an edge: capture the extracted/extended load into the `readdata` register (0 for stores); go to DONE.
  - Timeout counter increments each REQ cycle. Reaching TIMEOUT without ready: drop `bus_valid`, set errflags[1], load `readdata` = 0, go to DONE.
- DONE:
  - `stall` = 0 and `readdata` = captured value, so the datapath writes back and advances the PC at the end of this cycle.
  - Inputs are ignored (the same instruction is still presented).
  - Always goes to IDLE; counter cleared.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- Write data:
  - byte: {4{wd[7:0]}}.
  - half: {2{wd[15:0]}}.
  - word: wd.
- Load extraction:
  - lane = rdata >> (8*addr[1:0]).
  - byte: extend lane[7:0]; half: extend lane[15:0].
  - Sign-extend unless `unsignedload`. Word passes through unchanged.
- Reset (asserted at any time, including mid-REQ): immediately state IDLE, `bus_valid` 0, all bus outputs 0, `readdata` 0, errflags 0, counter 0. `stall` then follows the IDLE rule.

## Timing
- Reset values: bus_valid 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, readdata 0, errflags 0. stall and misaligned are combinational from the IDLE inputs.
- Minimum access takes 3 cycles (IDLE detect, REQ with ready, DONE). Each additional wait cycle adds 1.
- Timed-out access: exactly TIMEOUT REQ cycles, then DONE.
- `bus_valid` never deasserts before ready, except on timeout or reset. It never asserts in DONE or IDLE.
- Exactly one bus transaction per memory instruction. Back-to-back memory instructions are separated by the DONE → IDLE cycle.

## Test plan
- lw addr=0x10010004, ready after 2 wait cycles, rdata=0xDEADBEEF:
  - bus_be=1111, bus_addr=0x10010004.
  - stall high for 4 cycles.
  - readdata=0xDEADBEEF in DONE.
- lb / lbu addr=0x10010003, rdata=0x80FF1234:
  - be=1000.
  - lb readdata=0xFFFFFF80; lbu readdata=0x00000080.
- sh addr=0x10010002, writedata=0x0000ABCD:
  - bus_we=1, be=1100, bus_wdata=0xABCDABCD.
  - readdata=0 in DONE.
- lw addr=0x10010006:
  - no bus_valid, stall=0, misaligned=1.
  - errflags=01 afterwards.
- TIMEOUT=4, lw with bus_ready held low:
  - valid for exactly 4 cycles, then DONE with readdata=0.
  - errflags=10.
- reset pulsed low during REQ:
  - bus_valid drops without waiting for a clock; errflags=00.
  - A following lw completes normally.
